// File: rtl/sample_tree_pkg.sv
// Shared width helpers and packed-bus slicing for the topic-sampling tree.
// Pure functions only; no state.
package sample_tree_pkg;

   function automatic int sum_width(input int p_w, input int radix);
      return p_w + $clog2(radix);
   endfunction

   function automatic int idx_width(input int radix);
      return (radix > 2) ? $clog2(radix) : 1;
   endfunction

   // Low bit of element k in a bus of w-bit elements packed from bit 0 upward.
   function automatic int slice_lo(input int k, input int w);
      return k * w;
   endfunction

endpackage

// File: rtl/tree_prefix_select.sv
// Combinational pick of the smallest child whose inclusive prefix exceeds thr.
// No latency, no handshake; a zero total yields index 0 with zero_o set.
module tree_prefix_select
   import sample_tree_pkg::*;
#(
   parameter int RADIX = 2,
   parameter int SUM_W = 33,
   parameter int IDX_W = 1
) (
   input  logic [RADIX*SUM_W-1:0] prefix_i,
   input  logic [SUM_W-1:0]       thr_i,
   output logic [IDX_W-1:0]       idx_o,
   output logic                   zero_o
);

   always_comb begin
      idx_o  = '0;
      zero_o = (prefix_i[slice_lo(RADIX-1, SUM_W) +: SUM_W] == '0);
      // Descending scan so the lowest matching child is the last assignment.
      for (int k = RADIX-1; k >= 0; k--) begin
         if (thr_i < prefix_i[slice_lo(k, SUM_W) +: SUM_W]) begin
            idx_o = IDX_W'(k);
         end
      end
   end

endmodule

// File: rtl/sample_tree_node.sv
// K-ary sampling-tree node: 3-stage pipeline (prefix, threshold multiply, select).
// Latency 3, one transaction per cycle; all stages stall together when the output is held.
module sample_tree_node
   import sample_tree_pkg::*;
#(
   parameter int RADIX   = 2,
   parameter int P_W     = 32,
   parameter int TOPIC_W = 32,
   parameter int RAND_W  = 32,
   localparam int SUM_W  = sum_width(P_W, RADIX),
   localparam int IDX_W  = idx_width(RADIX)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_valid,
   output logic                     o_ready,
   input  logic [RADIX*P_W-1:0]     i_p,
   input  logic [RADIX-1:0]         i_mask,
   input  logic [RADIX*TOPIC_W-1:0] i_topic,
   input  logic [RAND_W-1:0]        i_random,
   output logic                     o_valid,
   input  logic                     i_ready,
   output logic [TOPIC_W-1:0]       o_topic,
   output logic [IDX_W-1:0]         o_idx,
   output logic [SUM_W-1:0]         o_p_sum,
   output logic                     o_zero
);

   localparam int PRE_W  = RADIX * SUM_W;
   localparam int TOP_W  = RADIX * TOPIC_W;
   localparam int PROD_W = RAND_W + SUM_W;

   logic               en;
   logic               v1_q, v2_q, o_valid_q;
   logic [SUM_W-1:0]   acc;
   logic [PRE_W-1:0]   pre_d, pre1_q, pre2_q;
   logic [TOP_W-1:0]   top1_q, top2_q;
   logic [RAND_W-1:0]  rnd1_q;
   logic [PROD_W-1:0]  prod;
   logic [SUM_W-1:0]   thr_d, thr2_q;
   logic [IDX_W-1:0]   sel_idx, o_idx_q;
   logic               sel_zero, o_zero_q;
   logic [TOPIC_W-1:0] o_topic_d, o_topic_q;
   logic [SUM_W-1:0]   o_p_sum_q;

   assign en      = !o_valid_q || i_ready;
   assign o_ready = en;

   // Masked weights folded straight into running prefix sums; SUM_W cannot overflow.
   always_comb begin
      acc   = '0;
      pre_d = '0;
      for (int k = 0; k < RADIX; k++) begin
         if (i_mask[k]) begin
            acc = acc + SUM_W'(i_p[slice_lo(k, P_W) +: P_W]);
         end
         pre_d[slice_lo(k, SUM_W) +: SUM_W] = acc;
      end
   end

   // The random word is a fraction in [0,1): thr = floor(random * total / 2^RAND_W).
   assign prod  = PROD_W'(rnd1_q) * PROD_W'(pre1_q[slice_lo(RADIX-1, SUM_W) +: SUM_W]);
   assign thr_d = SUM_W'(prod >> RAND_W);

   tree_prefix_select #(
      .RADIX (RADIX),
      .SUM_W (SUM_W),
      .IDX_W (IDX_W)
   ) u_select (
      .prefix_i (pre2_q),
      .thr_i    (thr2_q),
      .idx_o    (sel_idx),
      .zero_o   (sel_zero)
   );

   always_comb begin
      o_topic_d = '0;
      if (!sel_zero) begin
         o_topic_d = top2_q[slice_lo(int'(sel_idx), TOPIC_W) +: TOPIC_W];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q      <= 1'b0;
         v2_q      <= 1'b0;
         o_valid_q <= 1'b0;
         pre1_q    <= '0;
         pre2_q    <= '0;
         top1_q    <= '0;
         top2_q    <= '0;
         rnd1_q    <= '0;
         thr2_q    <= '0;
         o_topic_q <= '0;
         o_idx_q   <= '0;
         o_p_sum_q <= '0;
         o_zero_q  <= 1'b0;
      end else if (en) begin
         v1_q      <= i_valid;
         pre1_q    <= pre_d;
         top1_q    <= i_topic;
         rnd1_q    <= i_random;
         v2_q      <= v1_q;
         pre2_q    <= pre1_q;
         top2_q    <= top1_q;
         thr2_q    <= thr_d;
         o_valid_q <= v2_q;
         o_topic_q <= o_topic_d;
         o_idx_q   <= sel_idx;
         o_p_sum_q <= pre2_q[slice_lo(RADIX-1, SUM_W) +: SUM_W];
         o_zero_q  <= sel_zero;
      end
   end

   assign o_valid = o_valid_q;
   assign o_topic = o_topic_q;
   assign o_idx   = o_idx_q;
   assign o_p_sum = o_p_sum_q;
   assign o_zero  = o_zero_q;

endmodule

// File: tb/tb_sample_tree_node.sv
// Randomised and directed checks of sample_tree_node (RADIX=4) against a
// weighted-selection model; outputs compared at every falling edge.
module tb_sample_tree_node;
   localparam int RADIX   = 4;
   localparam int P_W     = 32;
   localparam int TOPIC_W = 32;
   localparam int RAND_W  = 32;
   localparam int SUM_W   = 34;
   localparam int IDX_W   = 2;

   logic                           clk = 1'b0;
   logic                           rst_n;
   logic                           i_valid, o_ready, o_valid, i_ready, o_zero;
   logic [RADIX-1:0][P_W-1:0]      i_p;
   logic [RADIX-1:0]               i_mask;
   logic [RADIX-1:0][TOPIC_W-1:0]  i_topic;
   logic [RAND_W-1:0]              i_random;
   logic [TOPIC_W-1:0]             o_topic;
   logic [IDX_W-1:0]               o_idx;
   logic [SUM_W-1:0]               o_p_sum;

   typedef struct packed {
      logic [RADIX-1:0][P_W-1:0] w;
      logic [TOPIC_W-1:0]        topic;
      logic [IDX_W-1:0]          idx;
      logic [SUM_W-1:0]          sum;
      logic                      zero;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   logic prev_stall = 1'b0;
   logic [69:0] prev_vec = '0;

   sample_tree_node #(
      .RADIX(RADIX), .P_W(P_W), .TOPIC_W(TOPIC_W), .RAND_W(RAND_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
      .i_p(i_p), .i_mask(i_mask), .i_topic(i_topic), .i_random(i_random),
      .o_valid(o_valid), .i_ready(i_ready), .o_topic(o_topic), .o_idx(o_idx),
      .o_p_sum(o_p_sum), .o_zero(o_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Draw a point uniformly on [0,total) and find which child's weight interval holds it.
   function automatic exp_t model(input logic [RADIX-1:0][P_W-1:0] p, input logic [RADIX-1:0] m,
                                  input logic [RADIX-1:0][TOPIC_W-1:0] t, input logic [RAND_W-1:0] r);
      exp_t        e;
      logic [95:0] total, point, upper;
      logic        found;
      e = '0;
      total = '0;
      for (int k = 0; k < RADIX; k++) begin
         e.w[k] = m[k] ? p[k] : '0;
         total  = total + 96'(e.w[k]);
      end
      point = (96'(r) * total) >> RAND_W;
      upper = '0;
      found = 1'b0;
      for (int k = 0; k < RADIX; k++) begin
         upper = upper + 96'(e.w[k]);
         if (!found && point < upper) begin
            found   = 1'b1;
            e.idx   = IDX_W'(k);
            e.topic = t[k];
         end
      end
      e.sum  = SUM_W'(total);
      e.zero = (total == 0);
      return e;
   endfunction

   // Compare process: every falling edge, away from the active edge.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         check("o_ready", 128'(o_ready), 128'(!(o_valid && !i_ready)));
         if (prev_stall) check("stall_hold", 128'({o_valid, o_topic, o_idx, o_p_sum, o_zero}), 128'(prev_vec));
         if (o_valid) begin
            if (q.size() == 0) begin
               check("unexpected_output", 128'(1), 128'(0));
            end else begin
               e = q[0];
               check("topic", 128'(o_topic), 128'(e.topic));
               check("idx",   128'(o_idx),   128'(e.idx));
               check("p_sum", 128'(o_p_sum), 128'(e.sum));
               check("zero",  128'(o_zero),  128'(e.zero));
               if (!o_zero) check("nonzero_pick", 128'(e.w[o_idx] != 0), 128'(1));
               if (i_ready) void'(q.pop_front());
            end
         end
         if (i_valid && o_ready) q.push_back(model(i_p, i_mask, i_topic, i_random));
         prev_stall = o_valid && !i_ready;
         prev_vec   = {o_valid, o_topic, o_idx, o_p_sum, o_zero};
      end
   end

   function automatic logic [P_W-1:0] rand_w();
      case ($urandom_range(0, 3))
         0:       return '0;
         1:       return P_W'($urandom_range(1, 20));
         default: return P_W'($urandom());
      endcase
   endfunction

   function automatic logic [RAND_W-1:0] rand_r();
      case ($urandom_range(0, 9))
         0:       return '0;
         1:       return '1;
         default: return RAND_W'($urandom());
      endcase
   endfunction

   task automatic new_txn();
      for (int k = 0; k < RADIX; k++) begin
         i_p[k]     = rand_w();
         i_topic[k] = TOPIC_W'($urandom());
      end
      i_mask   = RADIX'($urandom());
      i_random = rand_r();
   endtask

   task automatic drain();
      i_valid = 1'b0;
      i_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (q.size() == 0) break;
         @(posedge clk); #1;
      end
      check("drain_empty", 128'(q.size()), 128'(0));
   endtask

   // One transaction into an idle pipe with literal expectations and a latency check.
   task automatic directed(input string name, input logic [RADIX-1:0][P_W-1:0] p, input logic [RADIX-1:0] m,
                           input logic [RAND_W-1:0] r, input logic [IDX_W-1:0] eidx,
                           input logic [SUM_W-1:0] esum, input logic ezero);
      logic [RADIX-1:0][TOPIC_W-1:0] t;
      drain();
      for (int k = 0; k < RADIX; k++) t[k] = 32'hA000_0000 + TOPIC_W'((k + 1) * 32'h1111);
      i_p = p; i_mask = m; i_topic = t; i_random = r; i_valid = 1'b1;
      @(posedge clk); #1;
      i_valid = 1'b0;
      check({name, "_lat1"}, 128'(o_valid), 128'(0));
      @(posedge clk); #1;
      check({name, "_lat2"}, 128'(o_valid), 128'(0));
      @(posedge clk); #1;
      check({name, "_valid"}, 128'(o_valid), 128'(1));
      check({name, "_idx"},   128'(o_idx),   128'(eidx));
      check({name, "_sum"},   128'(o_p_sum), 128'(esum));
      check({name, "_zero"},  128'(o_zero),  128'(ezero));
      check({name, "_topic"}, 128'(o_topic), 128'(ezero ? 32'h0 : t[eidx]));
      @(posedge clk); #1;
   endtask

   // Handshake-respecting stream; mode 0 random valid/ready, mode 1 ready pattern 1,0,0,1.
   task automatic stream(input int cycles, input int mode);
      logic acc;
      acc = 1'b1;
      for (int c = 0; c < cycles; c++) begin
         if (mode == 1) i_ready = (c % 4 == 0) || (c % 4 == 3);
         else           i_ready = ($urandom_range(0, 9) < 6);
         if (!i_valid || acc) begin
            i_valid = (mode == 1) ? 1'b1 : ($urandom_range(0, 9) < 7);
            new_txn();
         end
         @(negedge clk);
         acc = i_valid && o_ready;
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
      i_p = '0; i_mask = '0; i_topic = '0; i_random = '0;
      #1;
      check("rst_o_valid", 128'(o_valid), 128'(0));
      check("rst_o_topic", 128'(o_topic), 128'(0));
      check("rst_o_idx",   128'(o_idx),   128'(0));
      check("rst_o_p_sum", 128'(o_p_sum), 128'(0));
      check("rst_o_zero",  128'(o_zero),  128'(0));
      check("rst_o_ready", 128'(o_ready), 128'(1));
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      directed("r2_half",  {32'd0, 32'd0, 32'd10, 32'd30}, 4'b0011, 32'h8000_0000, 2'd0, 34'd40, 1'b0);
      directed("r2_3q",    {32'd0, 32'd0, 32'd10, 32'd30}, 4'b0011, 32'hC000_0000, 2'd1, 34'd40, 1'b0);
      directed("r2_ones",  {32'd0, 32'd0, 32'd10, 32'd30}, 4'b0011, 32'hFFFF_FFFF, 2'd1, 34'd40, 1'b0);
      directed("r4_0505",  {32'd5, 32'd0, 32'd5, 32'd0},   4'b1111, 32'h8000_0000, 2'd3, 34'd10, 1'b0);
      directed("mask0",    {32'd1, 32'd2, 32'd3, 32'd4},   4'b0000, 32'h1234_5678, 2'd0, 34'd0,  1'b1);
      directed("allzero",  {32'd0, 32'd0, 32'd0, 32'd0},   4'b1111, 32'hFFFF_FFFF, 2'd0, 34'd0,  1'b1);
      directed("m0010_a",  {32'd1, 32'd2, 32'd9, 32'd7},   4'b0010, 32'h1234_5678, 2'd1, 34'd9,  1'b0);
      directed("m0010_b",  {32'd1, 32'd2, 32'd9, 32'd7},   4'b0010, 32'hFFFF_FFFF, 2'd1, 34'd9,  1'b0);
      directed("ones_last",{32'd0, 32'd5, 32'd3, 32'd0},   4'b1111, 32'hFFFF_FFFF, 2'd2, 34'd8,  1'b0);
      directed("zero_first",{32'd0, 32'd5, 32'd3, 32'd0},  4'b1111, 32'h0000_0000, 2'd1, 34'd8,  1'b0);
      directed("max_w",    {4{32'hFFFF_FFFF}},            4'b1111, 32'hFFFF_FFFF, 2'd3, 34'h3_FFFF_FFFC, 1'b0);

      // Zero-weight children 0 and 2 must never win across many random words.
      drain();
      i_valid = 1'b1; i_ready = 1'b1; i_mask = 4'b1111;
      i_p = {32'd5, 32'd0, 32'd5, 32'd0};
      for (int k = 0; k < RADIX; k++) i_topic[k] = TOPIC_W'(k + 100);
      for (int c = 0; c < 10000; c++) begin
         i_random = RAND_W'($urandom());
         @(posedge clk); #1;
      end
      drain();

      stream(60, 1);
      drain();
      stream(3000, 0);
      drain();

      // Reset with three transactions in flight: everything must clear at once.
      i_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         i_valid = 1'b1;
         new_txn();
         @(posedge clk); #1;
      end
      rst_n = 1'b0; i_valid = 1'b0;
      q.delete();
      #1;
      check("mid_rst_o_valid", 128'(o_valid), 128'(0));
      check("mid_rst_o_topic", 128'(o_topic), 128'(0));
      check("mid_rst_o_idx",   128'(o_idx),   128'(0));
      check("mid_rst_o_p_sum", 128'(o_p_sum), 128'(0));
      check("mid_rst_o_zero",  128'(o_zero),  128'(0));
      check("mid_rst_o_ready", 128'(o_ready), 128'(1));
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      directed("post_rst", {32'd0, 32'd0, 32'd10, 32'd30}, 4'b0011, 32'h8000_0000, 2'd0, 34'd40, 1'b0);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
